gs_elim_engine: RTL
===================

GS_ELIM_ENGINE -- requirements
Module: gs_elim_engine

Interface
REQ-001 SHALL have parameter DAT_W, default 16: row width in bits, equal to the matrix column count.
REQ-002 SHALL have parameter DAT_D, default 16: maximum row count, equal to the memory depth.
REQ-003 SHALL have parameter READ_DELAY, default 2 (legal values 1..4): cycles from address drive to valid mem_din.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: one-cycle job request, sampled only in IDLE.
REQ-007 SHALL have port mode, input, 1 bit: 0 = rank only, no writes; 1 = echelon write-back. Sampled with start.
REQ-008 SHALL have port nrows, input, CLOG2(DAT_D+1) bits: rows to process, 0..DAT_D. Sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after start until done.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rank, output, CLOG2(DAT_W+1) bits: matrix rank, held until the next accepted start.
REQ-012 SHALL have port full_rank, output, 1 bit: rank == min(nrows, DAT_W), held with rank.
REQ-013 SHALL have port mem_din, input, DAT_W bits: row read data.
REQ-014 SHALL have port mem_dout, output, DAT_W bits: row write data.
REQ-015 SHALL have port mem_addr, output, CLOG2(DAT_D) bits: row address.
REQ-016 SHALL have port mem_rw, output, 1 bit: 1 = write, 0 = read.

Function
REQ-017 SHALL implement FSM states IDLE, RD, WAIT, RED, WR, ZWR, (BSUB, BWR when RREF is enabled), DONE.
REQ-018 SHALL hold a pivot bank piv[DAT_W-1:0] of DAT_W-bit rows plus piv_vld[DAT_W-1:0], cleared on every accepted start.
REQ-019 SHALL, when start is accepted in cycle T, drive row 0's address in cycle T+1 (RD).
REQ-020 SHALL sample mem_din for row i exactly READ_DELAY cycles after its address cycle, in state RED.
REQ-021 SHALL, in RED, reduce the row combinationally for j = DAT_W-1 down to 0: if row[j] and piv_vld[j], then row ^= piv[j].
REQ-022 SHALL, when a reduced row is nonzero with leading bit p, store piv[p] = row, set piv_vld[p] and increment rank in the same cycle.
REQ-023 SHALL, in mode 1, write the reduced row (zero if dependent) to the same address in the cycle after RED (WR, mem_rw=1 for exactly one cycle).
REQ-024 SHALL use a row period of READ_DELAY+2 cycles in mode 1 and READ_DELAY+1 cycles in mode 0; the next read follows immediately.
REQ-025 SHALL pulse done in cycle T+1+nrows*period, then return to IDLE.
REQ-026 SHALL stop reading once rank reaches DAT_W. In mode 1 each remaining row SHALL receive one zero write per cycle (ZWR); in mode 0 the FSM SHALL go directly to DONE.
REQ-027 SHALL, when nrows = 0, pulse done in cycle T+1 with rank = 0 and full_rank = 1.
REQ-028 SHALL ignore start while busy; a start coincident with done SHALL be ignored.
REQ-029 SHALL hold mem_rw = 0 and mem_dout = 0 in every state except WR, ZWR and BWR.

Reset
REQ-030 SHALL, on rst, force state IDLE, busy=0, done=0, rank=0, full_rank=0, mem_rw=0, mem_addr=0, mem_dout=0, and clear piv_vld, including mid-job.
REQ-031 SHALL give rst priority over start in the same cycle.

Configuration
REQ-032 SHALL support macro GS_ELIM_RREF_EN. When it is defined and mode = 1, the forward pass writes nothing. BSUB then clears, for each valid pivot from the highest leading bit down, that pivot's bits in every other pivot column, one pivot per cycle (DAT_W cycles). BWR then writes the pivots in descending leading-bit order to addresses 0..rank-1 and zeros to rank..nrows-1, one row per cycle, followed by DONE.
REQ-033 SHALL, when GS_ELIM_RREF_EN is undefined, omit BSUB/BWR logic entirely and produce in-place row-echelon output per REQ-023.

Verification (DAT_W=4, DAT_D=8, READ_DELAY=2 unless stated)
REQ-034 SHALL cover: mode 1, nrows=4, rows 1000,0100,0010,0001 -> same four rows written back; rank=4; full_rank=1; done at T+17.
REQ-035 SHALL cover: mode 1, rows 1100,0110,1010,0001 -> writes 1100,0110,0000,0001; rank=3; full_rank=0.
REQ-036 SHALL cover: mode 0, same rows as REQ-035 -> mem_rw never high; rank=3; done at T+13.
REQ-037 SHALL cover: mode 1, nrows=6, rows 0..3 identity -> rows 4 and 5 not read, each zero-written in one cycle; rank=4; full_rank=1.
REQ-038 SHALL cover: rst asserted during row 1 WAIT -> next cycle busy=0, rank=0, mem_rw=0; a fresh identity job then reports rank=4.
REQ-039 SHALL cover, with GS_ELIM_RREF_EN defined: mode 1, rows 1100,0110,0011 -> addresses 0..2 written 1001,0101,0011; rank=3; full_rank=1.

Source files
------------

// File: rtl/gs_elim_engine.sv
// GF(2) Gaussian elimination over rows streamed from a fixed-latency RAM; reports rank,
// optionally writes back row-echelon rows. Define GS_ELIM_RREF_EN for reduced-echelon write-back.
module gs_elim_engine #(
  parameter int DAT_W      = 16,
  parameter int DAT_D      = 16,
  parameter int READ_DELAY = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [$clog2(DAT_D+1)-1:0] nrows,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DAT_W+1)-1:0] rank,
  output logic                       full_rank,
  input  logic [DAT_W-1:0]           mem_din,
  output logic [DAT_W-1:0]           mem_dout,
  output logic [$clog2(DAT_D)-1:0]   mem_addr,
  output logic                       mem_rw
);
  localparam int NR_W = $clog2(DAT_D+1);
  localparam int RK_W = $clog2(DAT_W+1);
  localparam int AD_W = $clog2(DAT_D);
  localparam int LD_W = (DAT_W > 1) ? $clog2(DAT_W) : 1;
  localparam logic [1:0]      WAIT_INIT = 2'((READ_DELAY > 1) ? READ_DELAY - 2 : 0);
  localparam logic [RK_W-1:0] FULL_RK   = RK_W'(DAT_W);

  typedef enum logic [3:0] {
    IDLE, RD, WAIT, RED, WR, ZWR,
`ifdef GS_ELIM_RREF_EN
    BSUB, BWR,
`endif
    DONE
  } state_t;

  state_t                        state;
  logic                          mode_q;
  logic [NR_W-1:0]               nrows_q, row, row_nxt;
  logic [AD_W-1:0]               addr_nxt;
  logic [1:0]                    wcnt;
  logic [DAT_W-1:0][DAT_W-1:0]   piv;
  logic [DAT_W-1:0]              piv_vld;
  logic [DAT_W-1:0]              red;
  logic [LD_W-1:0]               lead;
  logic [RK_W-1:0]               rank_inc;
  logic                          row_last;

  assign row_nxt  = row + NR_W'(1);
  assign addr_nxt = AD_W'(row_nxt);
  assign row_last = (row_nxt == nrows_q);
  assign rank_inc = rank + RK_W'(red != '0);

  function automatic logic is_full(input logic [RK_W-1:0] r, input logic [NR_W-1:0] n);
    return int'(r) == ((int'(n) < DAT_W) ? int'(n) : DAT_W);
  endfunction

  // Reduce the incoming row against the pivot bank, highest column first.
  always_comb begin
    red = mem_din;
    for (int j = DAT_W-1; j >= 0; j--)
      if (red[j] && piv_vld[j]) red = red ^ piv[j];
    lead = '0;
    for (int j = 0; j < DAT_W; j++)
      if (red[j]) lead = LD_W'(j);
  end

`ifdef GS_ELIM_RREF_EN
  logic [DAT_W-1:0][DAT_W-1:0] piv_sub;
  logic [LD_W-1:0]             bcnt, top;

  // One back-substitution step: clear column bcnt from every other pivot.
  always_comb begin
    for (int m = 0; m < DAT_W; m++) begin
      piv_sub[m] = piv[m];
      if (piv_vld[bcnt] && piv_vld[m] && m != int'(bcnt) && piv[m][bcnt])
        piv_sub[m] = piv[m] ^ piv[bcnt];
    end
    top = '0;
    for (int j = 0; j < DAT_W; j++)
      if (piv_vld[j]) top = LD_W'(j);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rank      <= '0;
      full_rank <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_dout  <= '0;
      piv_vld   <= '0;
      mode_q    <= 1'b0;
      nrows_q   <= '0;
      row       <= '0;
      wcnt      <= '0;
`ifdef GS_ELIM_RREF_EN
      bcnt      <= '0;
`endif
    end else begin
      done     <= 1'b0;
      mem_rw   <= 1'b0;
      mem_dout <= '0;
      case (state)
        IDLE: if (start) begin
          busy      <= 1'b1;
          mode_q    <= mode;
          nrows_q   <= nrows;
          row       <= '0;
          mem_addr  <= '0;
          piv_vld   <= '0;
          rank      <= '0;
          full_rank <= 1'b0;
          if (nrows == '0) begin
            state     <= DONE;
            done      <= 1'b1;
            full_rank <= 1'b1;
          end else state <= RD;
        end
        RD: begin
          wcnt  <= WAIT_INIT;
          state <= (READ_DELAY > 1) ? WAIT : RED;
        end
        WAIT: if (wcnt == '0) state <= RED; else wcnt <= wcnt - 2'd1;
        RED: begin
          if (red != '0) begin
            piv[lead]     <= red;
            piv_vld[lead] <= 1'b1;
            rank          <= rank_inc;
          end
          if (mode_q) begin
`ifdef GS_ELIM_RREF_EN
            if (row_last || rank_inc == FULL_RK) begin
              state <= BSUB;
              bcnt  <= LD_W'(DAT_W-1);
            end else begin
              state    <= RD;
              row      <= row_nxt;
              mem_addr <= addr_nxt;
            end
`else
            state    <= WR;
            mem_rw   <= 1'b1;
            mem_dout <= red;
`endif
          end else if (row_last || rank_inc == FULL_RK) begin
            state     <= DONE;
            done      <= 1'b1;
            full_rank <= is_full(rank_inc, nrows_q);
          end else begin
            state    <= RD;
            row      <= row_nxt;
            mem_addr <= addr_nxt;
          end
        end
        // Once the bank is full, every remaining row can only reduce to zero.
        WR, ZWR: if (row_last) begin
          state     <= DONE;
          done      <= 1'b1;
          full_rank <= is_full(rank, nrows_q);
        end else begin
          row      <= row_nxt;
          mem_addr <= addr_nxt;
          if (rank == FULL_RK) begin
            state  <= ZWR;
            mem_rw <= 1'b1;
          end else state <= RD;
        end
`ifdef GS_ELIM_RREF_EN
        BSUB: begin
          piv <= piv_sub;
          if (bcnt == '0) begin
            state    <= BWR;
            row      <= '0;
            mem_addr <= '0;
            mem_rw   <= 1'b1;
            mem_dout <= (|piv_vld) ? piv_sub[top] : '0;
            if (|piv_vld) piv_vld[top] <= 1'b0;
          end else bcnt <= bcnt - LD_W'(1);
        end
        // Pivots drain highest-first by retiring each one's valid bit as it is written.
        BWR: if (row_last) begin
          state     <= DONE;
          done      <= 1'b1;
          full_rank <= is_full(rank, nrows_q);
        end else begin
          row      <= row_nxt;
          mem_addr <= addr_nxt;
          mem_rw   <= 1'b1;
          mem_dout <= (|piv_vld) ? piv[top] : '0;
          if (|piv_vld) piv_vld[top] <= 1'b0;
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
